// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register for the 5-stage MIPS core.
// Carries a valid bit alongside the decoded bundle, honours flush and stall,
// detects load-use hazards against the instruction now sitting in ID and
// inserts exactly one bubble per hazard. Two saturating event counters
// (bubbles, flushes) are kept for performance debug.
module id_ex_pipe_stage #(
    parameter int DATA_W      = 32,
    parameter int CTRL_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int MEMREAD_BIT = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] Control_in,
    input  logic [DATA_W-1:0] RsData_in,
    input  logic [DATA_W-1:0] RtData_in,
    input  logic [DATA_W-1:0] ALU_in,
    input  logic [ADDR_W-1:0] RsAddr_in,
    input  logic [ADDR_W-1:0] RtAddr_in,
    input  logic [ADDR_W-1:0] RdAddr_in,
    input  logic              clr_cnt,
    output logic              valid_out,
    output logic [CTRL_W-1:0] Control_out,
    output logic [DATA_W-1:0] RsData_out,
    output logic [DATA_W-1:0] RtData_out,
    output logic [DATA_W-1:0] ALU_out,
    output logic [ADDR_W-1:0] RsAddr_out,
    output logic [ADDR_W-1:0] RtAddr_out,
    output logic [ADDR_W-1:0] RdAddr_out,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [ADDR_W-1:0] REG_ZERO = {ADDR_W{1'b0}};
    localparam logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}};

    logic              valid_q,      valid_d;
    logic [CTRL_W-1:0] ctrl_q,       ctrl_d;
    logic [DATA_W-1:0] rs_data_q,    rs_data_d;
    logic [DATA_W-1:0] rt_data_q,    rt_data_d;
    logic [DATA_W-1:0] alu_q,        alu_d;
    logic [ADDR_W-1:0] rs_addr_q,    rs_addr_d;
    logic [ADDR_W-1:0] rt_addr_q,    rt_addr_d;
    logic [ADDR_W-1:0] rd_addr_q,    rd_addr_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;

    logic hazard_s;
    logic bubble_take_s;
    logic flush_take_s;

    // Load-use detection: a valid load in EX whose destination (non-$zero) is read by ID.
    always_comb begin
        hazard_s = valid_q & ctrl_q[MEMREAD_BIT] & (rt_addr_q != REG_ZERO) & valid_in
                   & ((rt_addr_q == RsAddr_in) | (rt_addr_q == RtAddr_in));
    end

    // Stage next-state: flush beats stall beats hazard bubble beats a normal load.
    always_comb begin
        valid_d       = valid_q;
        ctrl_d        = ctrl_q;
        rs_data_d     = rs_data_q;
        rt_data_d     = rt_data_q;
        alu_d         = alu_q;
        rs_addr_d     = rs_addr_q;
        rt_addr_d     = rt_addr_q;
        rd_addr_d     = rd_addr_q;
        bubble_take_s = 1'b0;
        flush_take_s  = 1'b0;
        if (flush_in) begin
            valid_d      = 1'b0;
            ctrl_d       = CTRL_NOP;
            flush_take_s = 1'b1;
        end else if (stall_in) begin
            valid_d = valid_q;
            ctrl_d  = ctrl_q;
        end else if (hazard_s) begin
            // The bubble clears MemRead, so the hazard cannot re-fire next cycle.
            valid_d       = 1'b0;
            ctrl_d        = CTRL_NOP;
            bubble_take_s = 1'b1;
        end else begin
            valid_d   = valid_in;
            ctrl_d    = valid_in ? Control_in : CTRL_NOP;
            rs_data_d = RsData_in;
            rt_data_d = RtData_in;
            alu_d     = ALU_in;
            rs_addr_d = RsAddr_in;
            rt_addr_d = RtAddr_in;
            rd_addr_d = RdAddr_in;
        end
    end

    // Event counters: clear wins over increment, increments saturate at all-ones.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (clr_cnt) begin
            bubble_cnt_d = CNT_ZERO;
            flush_cnt_d  = CNT_ZERO;
        end else begin
            if (bubble_take_s && (bubble_cnt_q != CNT_MAX)) begin
                bubble_cnt_d = bubble_cnt_q + CNT_ONE;
            end else begin
                bubble_cnt_d = bubble_cnt_q;
            end
            if (flush_take_s && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // State register with synchronous reset to an empty, zeroed stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            ctrl_q       <= CTRL_NOP;
            rs_data_q    <= {DATA_W{1'b0}};
            rt_data_q    <= {DATA_W{1'b0}};
            alu_q        <= {DATA_W{1'b0}};
            rs_addr_q    <= REG_ZERO;
            rt_addr_q    <= REG_ZERO;
            rd_addr_q    <= REG_ZERO;
            bubble_cnt_q <= CNT_ZERO;
            flush_cnt_q  <= CNT_ZERO;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            alu_q        <= alu_d;
            rs_addr_q    <= rs_addr_d;
            rt_addr_q    <= rt_addr_d;
            rd_addr_q    <= rd_addr_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // A flush squashes the ID instruction anyway, so no hold is requested then.
    always_comb begin
        hazard_stall = hazard_s & ~flush_in;
    end

    assign valid_out   = valid_q;
    assign Control_out = ctrl_q;
    assign RsData_out  = rs_data_q;
    assign RtData_out  = rt_data_q;
    assign ALU_out     = alu_q;
    assign RsAddr_out  = rs_addr_q;
    assign RtAddr_out  = rt_addr_q;
    assign RdAddr_out  = rd_addr_q;
    assign bubble_cnt  = bubble_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: reset sequence, a directed vector table,
// counter saturation on a narrow-counter instance, then randomized traffic
// checked against a behavioural model of the stage.
module tb_id_ex_pipe_stage;

    logic        clk;
    logic        rst, stall_in, flush_in, valid_in, clr_cnt;
    logic [7:0]  Control_in;
    logic [31:0] RsData_in, RtData_in, ALU_in;
    logic [4:0]  RsAddr_in, RtAddr_in, RdAddr_in;

    logic        valid_out, hazard_stall;
    logic [7:0]  Control_out;
    logic [31:0] RsData_out, RtData_out, ALU_out;
    logic [4:0]  RsAddr_out, RtAddr_out, RdAddr_out;
    logic [15:0] bubble_cnt, flush_cnt;

    logic        n_valid_out, n_hazard_stall;
    logic [7:0]  n_Control_out;
    logic [31:0] n_RsData_out, n_RtData_out, n_ALU_out;
    logic [4:0]  n_RsAddr_out, n_RtAddr_out, n_RdAddr_out;
    logic [1:0]  n_bubble_cnt, n_flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_pipe_stage u0 (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in), .valid_in(valid_in),
        .Control_in(Control_in), .RsData_in(RsData_in), .RtData_in(RtData_in), .ALU_in(ALU_in),
        .RsAddr_in(RsAddr_in), .RtAddr_in(RtAddr_in), .RdAddr_in(RdAddr_in), .clr_cnt(clr_cnt),
        .valid_out(valid_out), .Control_out(Control_out), .RsData_out(RsData_out),
        .RtData_out(RtData_out), .ALU_out(ALU_out), .RsAddr_out(RsAddr_out),
        .RtAddr_out(RtAddr_out), .RdAddr_out(RdAddr_out), .hazard_stall(hazard_stall),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_pipe_stage #(.CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in), .valid_in(valid_in),
        .Control_in(Control_in), .RsData_in(RsData_in), .RtData_in(RtData_in), .ALU_in(ALU_in),
        .RsAddr_in(RsAddr_in), .RtAddr_in(RtAddr_in), .RdAddr_in(RdAddr_in), .clr_cnt(clr_cnt),
        .valid_out(n_valid_out), .Control_out(n_Control_out), .RsData_out(n_RsData_out),
        .RtData_out(n_RtData_out), .ALU_out(n_ALU_out), .RsAddr_out(n_RsAddr_out),
        .RtAddr_out(n_RtAddr_out), .RdAddr_out(n_RdAddr_out), .hazard_stall(n_hazard_stall),
        .bubble_cnt(n_bubble_cnt), .flush_cnt(n_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, flush, valid, clr;
        logic [7:0]  ctrl;
        logic [31:0] rsd;
        logic [4:0]  rsa, rta;
        logic        exp_hz, exp_v;
        logic [7:0]  exp_ctrl;
        logic [31:0] exp_rsd;
        int          exp_bub, exp_fl;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic r, s, f, v, c, input logic [7:0] ct,
                                input logic [31:0] d, input logic [4:0] ra, rb,
                                input logic eh, ev, input logic [7:0] ec,
                                input logic [31:0] ed, input int eb, ef);
        vec_t x;
        x.rst = r; x.stall = s; x.flush = f; x.valid = v; x.clr = c;
        x.ctrl = ct; x.rsd = d; x.rsa = ra; x.rta = rb;
        x.exp_hz = eh; x.exp_v = ev; x.exp_ctrl = ec; x.exp_rsd = ed;
        x.exp_bub = eb; x.exp_fl = ef;
        return x;
    endfunction

    // Secondary fields are derived from RsData so one expected value covers them.
    function automatic logic [31:0] swap16(input logic [31:0] d);
        return {d[15:0], d[31:16]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model state
    logic        m_v;
    logic [7:0]  m_ctrl;
    logic [31:0] m_rsd, m_rtd, m_alu;
    logic [4:0]  m_rsa, m_rta, m_rda;
    int          m_bub, m_fl, m_bub2, m_fl2;
    logic        m_hz;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    initial begin
        rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0; valid_in = 1'b0; clr_cnt = 1'b0;
        Control_in = 8'h00; RsData_in = 32'h0; RtData_in = 32'h0; ALU_in = 32'h0;
        RsAddr_in = 5'd0; RtAddr_in = 5'd0; RdAddr_in = 5'd0;

        // Reset held for two clocks with random inputs
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1;
            stall_in = 1'($urandom); flush_in = 1'($urandom); valid_in = 1'b1;
            clr_cnt = 1'($urandom); Control_in = 8'($urandom); RsData_in = $urandom;
            RtData_in = $urandom; ALU_in = $urandom;
            RsAddr_in = 5'($urandom); RtAddr_in = 5'($urandom); RdAddr_in = 5'($urandom);
        end
        @(posedge clk); #1;
        chk("rst_valid", 64'(valid_out), 64'h0);
        chk("rst_ctrl", 64'(Control_out), 64'h0);
        chk("rst_data", 64'(RsData_out | RtData_out | ALU_out), 64'h0);
        chk("rst_addr", 64'(RsAddr_out | RtAddr_out | RdAddr_out), 64'h0);
        chk("rst_cnt", 64'(bubble_cnt | flush_cnt), 64'h0);
        chk("rst_hazard", 64'(hazard_stall), 64'h0);

        //          rst  stl  fl   v    clr  ctrl   rsd       rsa  rta   hz   ev   ectrl  ersd      bub fl
        tbl[0]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,8'h5A,32'h1234,5'd1,5'd2, 1'b0,1'b1,8'h5A,32'h1234,0,0);
        tbl[1]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,8'h08,32'h000A,5'd6,5'd5, 1'b0,1'b1,8'h08,32'h000A,0,0);
        tbl[2]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,8'h22,32'h000B,5'd5,5'd7, 1'b1,1'b0,8'h00,32'h000A,1,0);
        tbl[3]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,8'h22,32'h000B,5'd5,5'd7, 1'b0,1'b1,8'h22,32'h000B,1,0);
        tbl[4]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,8'h08,32'h000C,5'd1,5'd0, 1'b0,1'b1,8'h08,32'h000C,1,0);
        tbl[5]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,8'h01,32'h000D,5'd0,5'd0, 1'b0,1'b1,8'h01,32'h000D,1,0);
        tbl[6]  = mk(1'b0,1'b1,1'b1,1'b1,1'b0,8'hFF,32'h000E,5'd0,5'd0, 1'b0,1'b0,8'h00,32'h000D,1,1);
        tbl[7]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,8'h44,32'h00F0,5'd3,5'd4, 1'b0,1'b1,8'h44,32'h00F0,1,1);
        tbl[8]  = mk(1'b0,1'b1,1'b0,1'b1,1'b0,8'h99,32'h0111,5'd3,5'd4, 1'b0,1'b1,8'h44,32'h00F0,1,1);
        tbl[9]  = mk(1'b0,1'b1,1'b0,1'b1,1'b0,8'h99,32'h0222,5'd3,5'd4, 1'b0,1'b1,8'h44,32'h00F0,1,1);
        tbl[10] = mk(1'b0,1'b1,1'b0,1'b1,1'b0,8'h99,32'h0333,5'd3,5'd4, 1'b0,1'b1,8'h44,32'h00F0,1,1);
        tbl[11] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,8'h08,32'h0100,5'd1,5'd9, 1'b0,1'b1,8'h08,32'h0100,1,1);
        tbl[12] = mk(1'b0,1'b1,1'b0,1'b1,1'b0,8'h11,32'h0200,5'd9,5'd1, 1'b1,1'b1,8'h08,32'h0100,1,1);
        tbl[13] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,8'h11,32'h0200,5'd9,5'd1, 1'b1,1'b0,8'h00,32'h0100,2,1);
        tbl[14] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,8'hFF,32'h0300,5'd9,5'd9, 1'b0,1'b0,8'h00,32'h0300,2,1);
        tbl[15] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,8'h08,32'h0400,5'd1,5'd6, 1'b0,1'b1,8'h08,32'h0400,2,1);
        tbl[16] = mk(1'b0,1'b0,1'b1,1'b1,1'b0,8'h22,32'h0500,5'd6,5'd1, 1'b0,1'b0,8'h00,32'h0400,2,2);
        tbl[17] = mk(1'b0,1'b0,1'b1,1'b1,1'b1,8'h33,32'h0600,5'd0,5'd0, 1'b0,1'b0,8'h00,32'h0400,0,0);
        tbl[18] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,8'h08,32'h0700,5'd1,5'd3, 1'b0,1'b1,8'h08,32'h0700,0,0);
        tbl[19] = mk(1'b1,1'b1,1'b0,1'b1,1'b0,8'h55,32'h0800,5'd3,5'd2, 1'b1,1'b0,8'h00,32'h0000,0,0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; stall_in = tbl[i].stall; flush_in = tbl[i].flush;
            valid_in = tbl[i].valid; clr_cnt = tbl[i].clr; Control_in = tbl[i].ctrl;
            RsData_in = tbl[i].rsd; RtData_in = swap16(tbl[i].rsd); ALU_in = tbl[i].rsd << 1;
            RsAddr_in = tbl[i].rsa; RtAddr_in = tbl[i].rta; RdAddr_in = tbl[i].rsa ^ tbl[i].rta;
            #1;
            chk($sformatf("t%0d_hazard", i), 64'(hazard_stall), 64'(tbl[i].exp_hz));
            @(posedge clk); #1;
            chk($sformatf("t%0d_valid", i), 64'(valid_out), 64'(tbl[i].exp_v));
            chk($sformatf("t%0d_ctrl", i), 64'(Control_out), 64'(tbl[i].exp_ctrl));
            chk($sformatf("t%0d_rsdata", i), 64'(RsData_out), 64'(tbl[i].exp_rsd));
            chk($sformatf("t%0d_rtdata", i), 64'(RtData_out), 64'(swap16(tbl[i].exp_rsd)));
            chk($sformatf("t%0d_alu", i), 64'(ALU_out), 64'(tbl[i].exp_rsd << 1));
            chk($sformatf("t%0d_bubble", i), 64'(bubble_cnt), 64'(tbl[i].exp_bub));
            chk($sformatf("t%0d_flush", i), 64'(flush_cnt), 64'(tbl[i].exp_fl));
            chk($sformatf("t%0d_bubble2", i), 64'(n_bubble_cnt), 64'(sat(tbl[i].exp_bub, 3)));
            chk($sformatf("t%0d_flush2", i), 64'(n_flush_cnt), 64'(sat(tbl[i].exp_fl, 3)));
        end

        // Five flushes: the 2-bit counter sticks at 3, the 16-bit one reaches 5
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            rst = 1'b0; stall_in = 1'b0; flush_in = 1'b1; valid_in = 1'b1; clr_cnt = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("sat%0d_flush", i), 64'(flush_cnt), 64'(i));
            chk($sformatf("sat%0d_flush2", i), 64'(n_flush_cnt), 64'(sat(i, 3)));
        end
        // Clear with a simultaneous flush
        @(negedge clk);
        flush_in = 1'b1; clr_cnt = 1'b1;
        @(posedge clk); #1;
        chk("clr_flush", 64'(flush_cnt), 64'h0);
        chk("clr_flush2", 64'(n_flush_cnt), 64'h0);

        // Randomized traffic against the model; stage contents are zero here
        m_v = 1'b0; m_ctrl = 8'h00; m_rsd = 32'h0; m_rtd = 32'h0; m_alu = 32'h0;
        m_rsa = 5'd0; m_rta = 5'd0; m_rda = 5'd0;
        m_bub = 0; m_fl = 0; m_bub2 = 0; m_fl2 = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 59) == 0);
            stall_in = ($urandom_range(0, 6) == 0);
            flush_in = ($urandom_range(0, 9) == 0);
            valid_in = ($urandom_range(0, 7) != 0);
            clr_cnt = ($urandom_range(0, 49) == 0);
            Control_in = 8'($urandom);
            RsData_in = $urandom; RtData_in = $urandom; ALU_in = $urandom;
            RsAddr_in = 5'($urandom_range(0, 3));
            RtAddr_in = 5'($urandom_range(0, 3));
            RdAddr_in = 5'($urandom);
            m_hz = m_v && m_ctrl[3] && (m_rta != 5'd0) && valid_in
                   && (m_rta == RsAddr_in || m_rta == RtAddr_in);
            #1;
            chk($sformatf("r%0d_hazard", i), 64'(hazard_stall), 64'(m_hz && !flush_in));
            if (rst) begin
                m_v = 1'b0; m_ctrl = 8'h00; m_rsd = 32'h0; m_rtd = 32'h0; m_alu = 32'h0;
                m_rsa = 5'd0; m_rta = 5'd0; m_rda = 5'd0;
                m_bub = 0; m_fl = 0; m_bub2 = 0; m_fl2 = 0;
            end else begin
                if (flush_in) begin
                    m_v = 1'b0; m_ctrl = 8'h00;
                    m_fl = sat(m_fl + 1, 65535); m_fl2 = sat(m_fl2 + 1, 3);
                end else if (stall_in) begin
                    m_v = m_v;
                end else if (m_hz) begin
                    m_v = 1'b0; m_ctrl = 8'h00;
                    m_bub = sat(m_bub + 1, 65535); m_bub2 = sat(m_bub2 + 1, 3);
                end else begin
                    m_v = valid_in; m_ctrl = valid_in ? Control_in : 8'h00;
                    m_rsd = RsData_in; m_rtd = RtData_in; m_alu = ALU_in;
                    m_rsa = RsAddr_in; m_rta = RtAddr_in; m_rda = RdAddr_in;
                end
                if (clr_cnt) begin
                    m_bub = 0; m_fl = 0; m_bub2 = 0; m_fl2 = 0;
                end
            end
            @(posedge clk); #1;
            chk($sformatf("r%0d_valid", i), 64'(valid_out), 64'(m_v));
            chk($sformatf("r%0d_ctrl", i), 64'(Control_out), 64'(m_ctrl));
            chk($sformatf("r%0d_data", i), {RsData_out, RtData_out ^ ALU_out}, {m_rsd, m_rtd ^ m_alu});
            chk($sformatf("r%0d_alu", i), 64'(ALU_out), 64'(m_alu));
            chk($sformatf("r%0d_addr", i), 64'({RsAddr_out, RtAddr_out, RdAddr_out}),
                64'({m_rsa, m_rta, m_rda}));
            chk($sformatf("r%0d_cnt", i), 64'({bubble_cnt, flush_cnt}), 64'({16'(m_bub), 16'(m_fl)}));
            chk($sformatf("r%0d_cnt2", i), 64'({n_bubble_cnt, n_flush_cnt}),
                64'({2'(m_bub2), 2'(m_fl2)}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
